// File: rtl/poly_sub_decode.sv
// Lane-parallel w = v - s^T*u mod q over a 256-coefficient polynomial, LANES coefficients per clock.
// Define MSG_DECODE_EN to add the msg port carrying Compress_q(w,1) of each coefficient.
module poly_sub_decode #(
  parameter int LANES = 16,
  parameter int Q     = 3329
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [256*12-1:0]  v,
  input  logic [256*12-1:0]  su,
  output logic [256*12-1:0]  w,
`ifdef MSG_DECODE_EN
  output logic [255:0]       msg,
`endif
  output logic               busy,
  output logic               valid
);

  localparam int N    = 256;
  localparam int NCH  = N / LANES;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW   = LANES * 12;
  localparam logic [11:0] Q12 = 12'(Q);
  localparam logic [12:0] Q13 = 13'(Q);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [IDXW-1:0] idx_q;
  logic [N*12-1:0] vbuf_q, sbuf_q, w_q;
  logic            busy_q, valid_q;
  logic [CW-1:0]   v_chunk, s_chunk, w_chunk;
`ifdef MSG_DECODE_EN
  logic [N-1:0]     msg_q;
  logic [LANES-1:0] m_chunk;
`endif

  always_comb begin
    v_chunk = '0;
    s_chunk = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (idx_q == IDXW'(c)) begin
        v_chunk = vbuf_q[c*CW +: CW];
        s_chunk = sbuf_q[c*CW +: CW];
      end
    end
  end

  // One conditional subtract fully reduces a 12-bit input; one conditional add fixes the sign.
  always_comb begin
    logic [11:0] a, b;
    logic [12:0] d;
    a = '0;
    b = '0;
    d = '0;
    w_chunk = '0;
`ifdef MSG_DECODE_EN
    m_chunk = '0;
`endif
    for (int unsigned l = 0; l < LANES; l++) begin
      a = v_chunk[l*12 +: 12];
      b = s_chunk[l*12 +: 12];
      if (a >= Q12) a = a - Q12;
      if (b >= Q12) b = b - Q12;
      d = {1'b0, a} - {1'b0, b};
      if (d[12]) d = d + Q13;
      w_chunk[l*12 +: 12] = d[11:0];
`ifdef MSG_DECODE_EN
      m_chunk[l] = (d[11:0] >= 12'((Q + 3) / 4)) && (d[11:0] <= 12'((3 * Q) / 4));
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vbuf_q  <= '0;
      sbuf_q  <= '0;
      w_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef MSG_DECODE_EN
      msg_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            vbuf_q  <= v;
            sbuf_q  <= su;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int unsigned c = 0; c < NCH; c++) begin
            if (idx_q == IDXW'(c)) begin
              w_q[c*CW +: CW] <= w_chunk;
`ifdef MSG_DECODE_EN
              msg_q[c*LANES +: LANES] <= m_chunk;
`endif
            end
          end
          if (idx_q == IDXW'(NCH - 1)) begin
            idx_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign w     = w_q;
  assign busy  = busy_q;
  assign valid = valid_q;
`ifdef MSG_DECODE_EN
  assign msg   = msg_q;
`endif

endmodule

// File: tb/tb_poly_sub_decode.sv
// Scoreboard bench for poly_sub_decode: directed runs push expected w/msg, a monitor checks on valid rise.
module tb_poly_sub_decode;

  localparam int N = 256;

  logic            clk, rst, start;
  logic [N*12-1:0] v, su, w;
  logic            busy, valid;
`ifdef MSG_DECODE_EN
  logic [N-1:0]    msg;
`endif

  poly_sub_decode #(.LANES(16), .Q(3329)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .v     (v),
    .su    (su),
    .w     (w),
`ifdef MSG_DECODE_EN
    .msg   (msg),
`endif
    .busy  (busy),
    .valid (valid)
  );

  typedef struct {
    logic [N*12-1:0] ew;
    logic [N-1:0]    em;
    int              id;
  } exp_t;

  exp_t sbq[$];
  int   nvec = 0;
  int   nerr = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [N*12-1:0] fill(input logic [11:0] x);
    logic [N*12-1:0] r;
    for (int i = 0; i < N; i++) r[i*12 +: 12] = x;
    return r;
  endfunction

  task automatic check(input string nm, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  task automatic check_w(input string nm, input logic [N*12-1:0] act, input logic [N*12-1:0] req);
    int bad;
    bad = -1;
    nvec++;
    for (int i = N - 1; i >= 0; i--)
      if (act[i*12 +: 12] !== req[i*12 +: 12]) bad = i;
    if (bad >= 0) begin
      nerr++;
      $display("FAIL %s: coefficient %0d actual %0d required %0d", nm, bad,
               act[bad*12 +: 12], req[bad*12 +: 12]);
    end
  endtask

`ifdef MSG_DECODE_EN
  task automatic check_m(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask
`endif

  // Monitor: compare on each rising edge of valid, sampled on the falling clock edge.
  initial begin
    logic vp;
    exp_t e;
    vp = 1'b0;
    forever begin
      @(negedge clk);
      if (valid && !vp) begin
        if (sbq.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_valid: actual 1 required 0");
        end else begin
          e = sbq.pop_front();
          check_w($sformatf("run%0d_w", e.id), w, e.ew);
`ifdef MSG_DECODE_EN
          check_m($sformatf("run%0d_msg", e.id), msg, e.em);
`endif
        end
      end
      vp = valid;
    end
  end

  task automatic do_run(input int id, input logic [N*12-1:0] vv, input logic [N*12-1:0] ss,
                        input logic [N*12-1:0] ew, input logic [N-1:0] em, input bit pulse);
    int lat, bcnt;
    exp_t e;
    e.ew = ew;
    e.em = em;
    e.id = id;
    sbq.push_back(e);
    @(negedge clk);
    v     = vv;
    su    = ss;
    start = 1'b1;
    @(posedge clk);
    #1;
    check($sformatf("run%0d_valid_cleared", id), int'(valid), 0);
    check($sformatf("run%0d_busy_set", id), int'(busy), 1);
    if (!pulse) start = 1'b0;
    lat  = 0;
    bcnt = 1;
    for (int k = 1; k <= 40; k++) begin
      if (pulse) begin
        start = ~start;
        v     = fill(12'($urandom_range(0, 4095)));
        su    = fill(12'($urandom_range(0, 4095)));
      end
      @(posedge clk);
      #1;
      if (valid) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
    end
    start = 1'b0;
    check($sformatf("run%0d_latency", id), lat, 16);
    check($sformatf("run%0d_busy_cycles", id), bcnt, 16);
    check($sformatf("run%0d_busy_low_at_valid", id), int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("run%0d_valid_hold", id), int'(valid), 1);
    check_w($sformatf("run%0d_w_hold", id), w, ew);
  endtask

  initial begin
    logic [N*12-1:0] pv;
    logic [N-1:0]    pm;
    logic [11:0]     pat [4];
    pat[0] = 12'd832;
    pat[1] = 12'd833;
    pat[2] = 12'd2496;
    pat[3] = 12'd2497;
    for (int i = 0; i < N; i++) begin
      pv[i*12 +: 12] = pat[i % 4];
      pm[i] = ((i % 4) == 1) || ((i % 4) == 2);
    end

    rst   = 1'b1;
    start = 1'b0;
    v     = '0;
    su    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_w("reset_w", w, '0);
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(valid), 0);
`ifdef MSG_DECODE_EN
    check_m("reset_msg", msg, '0);
`endif
    @(negedge clk);
    rst = 1'b0;

    do_run(1, fill(12'd5),    fill(12'd10),   fill(12'd3324), '0, 1'b0);
    do_run(2, fill(12'd2000), fill(12'd0),    fill(12'd2000), '1, 1'b0);
    do_run(3, fill(12'd0),    fill(12'd3328), fill(12'd1),    '0, 1'b0);
    do_run(4, fill(12'd3328), fill(12'd3328), fill(12'd0),    '0, 1'b0);
    do_run(5, fill(12'd4095), fill(12'd0),    fill(12'd766),  '0, 1'b0);
    do_run(6, fill(12'd0),    fill(12'd4095), fill(12'd2563), '0, 1'b0);
    do_run(7, pv,             fill(12'd0),    pv,             pm, 1'b0);
    do_run(8, fill(12'd3000), fill(12'd1000), fill(12'd2000), '1, 1'b1);

    // Abort mid-run at idx=7 with an asynchronous reset between clock edges.
    @(negedge clk);
    v     = fill(12'd100);
    su    = fill(12'd50);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("abort_busy_before", int'(busy), 1);
    #3;
    rst = 1'b1;
    #1;
    check_w("abort_w", w, '0);
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(valid), 0);
`ifdef MSG_DECODE_EN
    check_m("abort_msg", msg, '0);
`endif
    #1;
    @(negedge clk);
    rst = 1'b0;

    do_run(9, fill(12'd100), fill(12'd50), fill(12'd50), '0, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
